// File: rtl/lcd_hd44780_pkg.sv
// Shared constants for the HD44780 LCD controller: state encoding, register map,
// register bit positions and the command codes that need the long post-write wait.
package lcd_hd44780_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STS_BUSY_BIT  = 0;
  localparam int STS_FULL_BIT  = 1;
  localparam int STS_EMPTY_BIT = 2;
  localparam int STS_OVF_BIT   = 3;
  localparam int STS_LVL_LSB   = 8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Clear and return-home are the slow instructions on the controller.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
    return !rs && (code == CMD_CLEAR || code == CMD_HOME || code == CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Show-ahead synchronous FIFO holding {rs, data} entries for the LCD sequencer.
// Flush has priority over push and pop in the same cycle.
module lcd_cmd_fifo #(
  parameter  int W     = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// Avalon-MM slave driving an HD44780 LCD in 8-bit mode: command/data FIFO plus a
// sequencer producing RS/data setup, EN pulse, hold and post-write wait.
module lcd_hd44780_ctrl
  import lcd_hd44780_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int TMR_W          = 20,
  parameter int SETUP_CYC      = 4,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 4,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 80000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              busy
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam longint TMR_MAX = (longint'(1) << TMR_W) - 1;

  localparam logic [TMR_W-1:0] T_SETUP = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] T_EN    = TMR_W'(EN_CYC - 1);
  localparam logic [TMR_W-1:0] T_HOLD  = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] T_SHORT = TMR_W'(SHORT_WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] T_LONG  = TMR_W'(LONG_WAIT_CYC - 1);

  if (DATA_W < 1 || DATA_W > 8) begin : g_bad_data_w
    $error("lcd_hd44780_ctrl: DATA_W must be 1..8");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_hd44780_ctrl: DEPTH must be a power of two in 2..256");
  end
  if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 || SHORT_WAIT_CYC < 1 || LONG_WAIT_CYC < 1)
  begin : g_bad_cyc
    $error("lcd_hd44780_ctrl: all timing parameters must be >= 1");
  end
  if (longint'(SETUP_CYC) > TMR_MAX || longint'(EN_CYC) > TMR_MAX ||
      longint'(HOLD_CYC) > TMR_MAX || longint'(SHORT_WAIT_CYC) > TMR_MAX ||
      longint'(LONG_WAIT_CYC) > TMR_MAX) begin : g_bad_tmr
    $error("lcd_hd44780_ctrl: timing parameter exceeds timer range");
  end

  logic              wr, push, flush, start;
  logic [DATA_W:0]   din, head;
  logic              full, empty;
  logic [LW-1:0]     level;
  logic              enable, overflow;
  logic [2:0]        state;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_done;
  logic [31:0]       rd;
  logic              unused_wdata;

  assign wr    = chipselect && !write_n;
  assign push  = wr && (address == ADDR_DATA || address == ADDR_CMD);
  assign din   = {address == ADDR_DATA, writedata[DATA_W-1:0]};
  assign flush = wr && address == ADDR_CTRL && writedata[CTRL_FLUSH_BIT];
  // A flush in the pop cycle wins: the head entry is discarded, not sent.
  assign start = state == ST_IDLE && enable && !empty && !flush;
  assign tmr_done = tmr == '0;

  assign lcd_rw = 1'b0;
  assign busy   = state != ST_IDLE || !empty;
  assign unused_wdata = &{1'b0, writedata};

  lcd_cmd_fifo #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .din    (din),
    .pop    (start),
    .flush  (flush),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr && address == ADDR_CTRL) enable <= writedata[CTRL_EN_BIT];
      if (push && full)
        overflow <= 1'b1;
      else if (wr && address == ADDR_STATUS && writedata[STS_OVF_BIT])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          lcd_rs   <= head[DATA_W];
          lcd_data <= head[DATA_W-1:0];
          tmr      <= T_SETUP;
          state    <= ST_SETUP;
        end
        ST_SETUP: if (tmr_done) begin
          lcd_en <= 1'b1;
          tmr    <= T_EN;
          state  <= ST_PULSE;
        end else tmr <= tmr - 1'b1;
        ST_PULSE: if (tmr_done) begin
          lcd_en <= 1'b0;
          tmr    <= T_HOLD;
          state  <= ST_HOLD;
        end else tmr <= tmr - 1'b1;
        ST_HOLD: if (tmr_done) begin
          tmr   <= is_long_cmd(lcd_rs, 8'(lcd_data)) ? T_LONG : T_SHORT;
          state <= ST_WAIT;
        end else tmr <= tmr - 1'b1;
        ST_WAIT: if (tmr_done) state <= ST_IDLE;
                 else tmr <= tmr - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      ADDR_STATUS: begin
        rd[STS_BUSY_BIT]  = busy;
        rd[STS_FULL_BIT]  = full;
        rd[STS_EMPTY_BIT] = empty;
        rd[STS_OVF_BIT]   = overflow;
        rd = rd | (32'(level) << STS_LVL_LSB);
      end
      ADDR_CTRL: rd[CTRL_EN_BIT] = enable;
      default:   rd = '0;
    endcase
    readdata = reset_n ? rd : '0;
  end

endmodule
